// File: rtl/monitoreo_scheduler.sv
// Round-robin sampling scheduler that time-shares one temperature monitor among N_CH sensors.
// Each served sample is held on temp_salida so the monitor's persistence filter sees one channel.
module monitoreo_scheduler #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned TEMP_W   = 10,
  parameter int unsigned HOLD_CYC = 6,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     en,
  input  logic [N_CH-1:0]          ch_mask,
  output logic [N_CH-1:0]          sens_req,
  input  logic [N_CH-1:0]          sens_ack,
  input  logic [N_CH*TEMP_W-1:0]   sens_dato,
  output logic [TEMP_W-1:0]        temp_salida,
  output logic                     mon_valid,
  input  logic                     alerta_in,
  output logic [$clog2(N_CH)-1:0]  canal_act,
  output logic [N_CH-1:0]          alerta_canal,
  output logic [N_CH-1:0]          timeout_err,
  input  logic [N_CH-1:0]          clr_err,
  output logic                     ronda_fin
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned HW = $clog2(HOLD_CYC);

  typedef enum logic [2:0] {StIdle, StSelect, StReq, StHold, StNext} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       rr_q, rr_d;
  logic [CW-1:0]       canal_act_q, canal_act_d;
  logic [N_CH-1:0]     sens_req_q, sens_req_d;
  logic [TEMP_W-1:0]   temp_q, temp_d;
  logic                mon_valid_q, mon_valid_d;
  logic [N_CH-1:0]     alerta_canal_q, alerta_canal_d;
  logic [N_CH-1:0]     timeout_err_q, timeout_err_d;
  logic                ronda_fin_q, ronda_fin_d;
  logic [TW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;

  // Next pick: lowest enabled channel above the pointer, else wrap to the lowest enabled one.
  logic          above_found;
  logic [CW-1:0] above_ch, low_ch, pick_ch;
  logic          pick_wrap;

  always_comb begin
    above_found = 1'b0;
    above_ch    = '0;
    low_ch      = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_ch = CW'(i);
        if (i > int'(rr_q)) begin
          above_found = 1'b1;
          above_ch    = CW'(i);
        end
      end
    end
    pick_ch   = above_found ? above_ch : low_ch;
    pick_wrap = ~above_found;
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    canal_act_d    = canal_act_q;
    sens_req_d     = sens_req_q;
    temp_d         = temp_q;
    mon_valid_d    = mon_valid_q;
    alerta_canal_d = alerta_canal_q;
    timeout_err_d  = timeout_err_q & ~clr_err;
    ronda_fin_d    = 1'b0;
    wait_cnt_d     = wait_cnt_q;
    hold_cnt_d     = hold_cnt_q;

    case (state_q)
      StIdle: begin
        if (en && |ch_mask) state_d = StSelect;
      end
      StSelect: begin
        if (|ch_mask) begin
          canal_act_d = pick_ch;
          rr_d        = pick_ch;
          sens_req_d  = N_CH'(1) << pick_ch;
          wait_cnt_d  = '0;
          state_d     = StReq;
        end else begin
          state_d = StIdle;
        end
      end
      StReq: begin
        if (sens_ack[canal_act_q]) begin
          temp_d      = sens_dato[int'(canal_act_q)*TEMP_W +: TEMP_W];
          mon_valid_d = 1'b1;
          sens_req_d  = '0;
          hold_cnt_d  = '0;
          state_d     = StHold;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          // Applied after the clr_err mask so a simultaneous clear loses.
          timeout_err_d[canal_act_q] = 1'b1;
          sens_req_d                 = '0;
          state_d                    = StNext;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_cnt_q == HW'(HOLD_CYC - 1)) begin
          alerta_canal_d[canal_act_q] = alerta_in;
          mon_valid_d                 = 1'b0;
          state_d                     = StNext;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StNext: begin
        ronda_fin_d = (|ch_mask) & pick_wrap;
        state_d     = en ? StSelect : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q        <= StIdle;
      rr_q           <= CW'(N_CH - 1);
      canal_act_q    <= '0;
      sens_req_q     <= '0;
      temp_q         <= '0;
      mon_valid_q    <= 1'b0;
      alerta_canal_q <= '0;
      timeout_err_q  <= '0;
      ronda_fin_q    <= 1'b0;
      wait_cnt_q     <= '0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      canal_act_q    <= canal_act_d;
      sens_req_q     <= sens_req_d;
      temp_q         <= temp_d;
      mon_valid_q    <= mon_valid_d;
      alerta_canal_q <= alerta_canal_d;
      timeout_err_q  <= timeout_err_d;
      ronda_fin_q    <= ronda_fin_d;
      wait_cnt_q     <= wait_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign sens_req     = sens_req_q;
  assign temp_salida  = temp_q;
  assign mon_valid    = mon_valid_q;
  assign canal_act    = canal_act_q;
  assign alerta_canal = alerta_canal_q;
  assign timeout_err  = timeout_err_q;
  assign ronda_fin    = ronda_fin_q;

endmodule

// File: tb/tb_monitoreo_scheduler.sv
// Directed bench for monitoreo_scheduler: sensor models with programmable ack delay,
// a 5-cycle cold-persistence monitor stub, and an event log sampled on the falling edge.
module tb_monitoreo_scheduler;

  logic        clk = 1'b0;
  logic        arst, en;
  logic [3:0]  ch_mask, sens_req, sens_ack, alerta_canal, timeout_err, clr_err;
  logic [39:0] sens_dato;
  logic [9:0]  temp_salida;
  logic        mon_valid, alerta_in, ronda_fin;
  logic [1:0]  canal_act;

  always #5 clk = ~clk;

  monitoreo_scheduler #(
    .N_CH(4), .TEMP_W(10), .HOLD_CYC(6), .TIMEOUT(15)
  ) dut (
    .clk(clk), .arst(arst), .en(en), .ch_mask(ch_mask),
    .sens_req(sens_req), .sens_ack(sens_ack), .sens_dato(sens_dato),
    .temp_salida(temp_salida), .mon_valid(mon_valid), .alerta_in(alerta_in),
    .canal_act(canal_act), .alerta_canal(alerta_canal), .timeout_err(timeout_err),
    .clr_err(clr_err), .ronda_fin(ronda_fin)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sensor models
  logic [9:0] dat [4];
  int         ack_dly [4];
  logic [3:0] never;
  int         req_cnt [4];

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) req_cnt[c] <= sens_req[c] ? req_cnt[c] + 1 : 0;
  end

  always_comb begin
    sens_ack  = '0;
    sens_dato = '0;
    for (int c = 0; c < 4; c++) begin
      sens_ack[c]            = sens_req[c] && !never[c] && (req_cnt[c] >= ack_dly[c]);
      sens_dato[c*10 +: 10]  = dat[c];
    end
  end

  // Monitor stub: alarm once a cold (<12.0 C) live sample has persisted 5 cycles
  int cold_cnt;
  always @(posedge clk or posedge arst) begin
    if (arst) cold_cnt <= 0;
    else if (mon_valid && temp_salida < 10'd120) cold_cnt <= cold_cnt + 1;
    else cold_cnt <= 0;
  end
  assign alerta_in = (cold_cnt >= 5);

  // Event log
  int         served [$];
  int         vals [$];
  int         runs [$];
  int         fin_ch [$];
  int         req1_cnt = 0;
  int         any_req = 0;
  int         onehot_bad = 0;
  int         run_len = 0;
  logic       prev_valid = 1'b0;
  logic       unstable = 1'b0;
  logic [9:0] last_temp = '0;

  always @(negedge clk) begin
    if (arst) begin
      served.delete();
      vals.delete();
      runs.delete();
      fin_ch.delete();
      prev_valid = 1'b0;
      run_len    = 0;
    end else begin
      if (mon_valid && !prev_valid) begin
        served.push_back(int'(canal_act));
        vals.push_back(int'(temp_salida));
        run_len   = 1;
        last_temp = temp_salida;
      end else if (mon_valid) begin
        run_len++;
        if (temp_salida !== last_temp) unstable = 1'b1;
      end else if (prev_valid) begin
        runs.push_back(run_len);
      end
      if (ronda_fin) fin_ch.push_back(int'(canal_act));
      if (sens_req[1]) req1_cnt++;
      if (sens_req != 4'b0) any_req++;
      if ($countones(sens_req) > 1) onehot_bad++;
      prev_valid = mon_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_served(input int n, input int budget);
    int k = 0;
    while (served.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (served.size() < n) check("wait_served", served.size(), n);
  endtask

  task automatic do_reset();
    en      = 1'b0;
    clr_err = '0;
    arst    = 1'b1;
    step(2);
    arst    = 1'b0;
    step(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  int exp_ord [5] = '{0, 1, 2, 3, 0};
  int exp_val [4] = '{220, 150, 300, 221};
  int base;
  int k;

  initial begin
    arst    = 1'b1;
    en      = 1'b0;
    ch_mask = '0;
    clr_err = '0;
    never   = '0;
    for (int c = 0; c < 4; c++) begin
      dat[c]     = 10'd220;
      ack_dly[c] = 0;
    end
    step(2);
    check("rst_req", sens_req, 0);
    check("rst_temp", temp_salida, 0);
    check("rst_valid", mon_valid, 0);
    check("rst_canal", canal_act, 0);
    check("rst_alarm", alerta_canal, 0);
    check("rst_err", timeout_err, 0);
    check("rst_fin", ronda_fin, 0);

    // Full round, all channels ack immediately
    ch_mask = 4'b1111;
    for (int c = 0; c < 4; c++) dat[c] = exp_val[c][9:0];
    arst = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
    check("lat_select", sens_req, 4'b0000);
    step(1);
    check("lat_req", sens_req, 4'b0001);
    wait_served(5, 200);
    for (int i = 0; i < 5; i++) check($sformatf("order%0d", i), served[i], exp_ord[i]);
    for (int i = 0; i < 4; i++) check($sformatf("val%0d", i), vals[i], exp_val[i]);
    for (int i = 0; i < 4; i++) check($sformatf("hold_len%0d", i), runs[i], 6);
    check("fin_count", fin_ch.size(), 1);
    check("fin_after_ch3", fin_ch[0], 3);
    check("round_alarm", alerta_canal, 0);

    // Reset pulse in the middle of ch1's hold
    wait_served(6, 100);
    step(2);
    arst = 1'b1;
    #1;
    check("midrst_valid", mon_valid, 0);
    check("midrst_temp", temp_salida, 0);
    check("midrst_canal", canal_act, 0);
    check("midrst_req", sens_req, 0);
    step(2);
    arst = 1'b0;
    wait_served(1, 50);
    check("post_rst_first", served[0], 0);

    // Alternating 0/2 with a cold ch2 sample
    do_reset();
    ch_mask = 4'b0101;
    dat[0] = 10'd220; dat[1] = 10'd220; dat[2] = 10'd100; dat[3] = 10'd220;
    en = 1'b1;
    wait_served(3, 200);
    check("alt_ch2", served[1], 2);
    check("alarm_set", alerta_canal, 4'b0100);
    dat[2] = 10'd220;
    wait_served(5, 200);
    check("alt_ch0", served[2], 0);
    check("alt_ch2b", served[3], 2);
    check("alarm_clear", alerta_canal, 4'b0000);
    check("alt_fin", fin_ch[0], 2);

    // ch1 never acks
    do_reset();
    dat[2] = 10'd220;
    never   = 4'b0010;
    ch_mask = 4'b0011;
    base    = req1_cnt;
    en = 1'b1;
    wait_served(2, 200);
    check("to_err", timeout_err, 4'b0010);
    check("to_next_ch0", served[1], 0);
    en = 1'b0;
    step(30);
    check("to_req_len", req1_cnt - base, 15);
    check("to_sticky", timeout_err, 4'b0010);
    clr_err = 4'b0010;
    step(1);
    clr_err = 4'b0000;
    check("to_clear", timeout_err, 4'b0000);

    // en dropped while ch1 waits for a late ack
    do_reset();
    never      = '0;
    ack_dly[1] = 3;
    ch_mask    = 4'b0011;
    en = 1'b1;
    k = 0;
    while (!sens_req[1] && k < 100) begin
      step(1);
      k++;
    end
    check("late_req_seen", sens_req[1], 1);
    en = 1'b0;
    wait_served(2, 100);
    base = any_req;
    step(30);
    check("late_ch1", served[1], 1);
    check("late_hold", runs[1], 6);
    check("late_nserved", served.size(), 2);
    check("late_no_req", any_req - base, 0);
    check("late_idle_valid", mon_valid, 0);
    ack_dly[1] = 0;

    // Empty mask, then single channel, then ch3 added mid-round
    do_reset();
    ch_mask = 4'b0000;
    base    = any_req;
    en = 1'b1;
    step(10);
    check("empty_no_req", any_req - base, 0);
    check("empty_no_serve", served.size(), 0);
    ch_mask = 4'b0001;
    wait_served(2, 100);
    check("single_fin", fin_ch.size(), 1);
    check("single_again", served[1], 0);
    ch_mask = 4'b1001;
    wait_served(3, 100);
    check("added_ch3", served[2], 3);
    check("added_no_fin", fin_ch.size(), 1);

    check("onehot", onehot_bad, 0);
    check("stable", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
